// File: rtl/prv_trap_sequencer.sv
// Trap sequencer between EX/MEM and the privilege block: prioritises raw events into a
// registered one-hot trap report, then runs the insert_pc / redirect / flush handshake.
module prv_trap_sequencer #(
    parameter int WORD_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_WAIT     = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_pc,
    input  logic [WORD_W-1:0] ex_insn,
    input  logic [WORD_W-1:0] ex_mem_addr,
    input  logic [8:0]        ex_exc,
    input  logic              ex_ret,
    input  logic              ex_wfi,
    input  logic              prot_fault_i,
    input  logic              prot_fault_l,
    input  logic              prot_fault_s,
    input  logic              priv_intr,
    input  logic              priv_insert_pc,
    input  logic [WORD_W-1:0] priv_pc,
    output logic [8:0]        exc_out,
    output logic              ret_out,
    output logic              wfi_out,
    output logic [WORD_W-1:0] epc,
    output logic [WORD_W-1:0] badaddr,
    output logic              pipe_clear,
    output logic              stall,
    output logic              redirect_valid,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              timeout_err
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(MAX_WAIT - 1);
    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);

    localparam int EXC_MAL_I   = 0;
    localparam int EXC_FAULT_I = 1;
    localparam int EXC_ILLEGAL = 2;
    localparam int EXC_BREAK   = 3;
    localparam int EXC_ENV     = 4;
    localparam int EXC_MAL_L   = 5;
    localparam int EXC_FAULT_L = 6;
    localparam int EXC_MAL_S   = 7;
    localparam int EXC_FAULT_S = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REPORT,
        S_WAIT_PC,
        S_FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [8:0]          exc_q, exc_d;
    logic                ret_q, ret_d;
    logic                wfi_q, wfi_d;
    logic [WORD_W-1:0]   epc_q, epc_d;
    logic [WORD_W-1:0]   bad_q, bad_d;
    logic                pipe_clear_q, pipe_clear_d;
    logic                stall_q, stall_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [WORD_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic                timeout_q, timeout_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic [8:0]          exc_eff;
    logic                sel_trap;
    logic                sel_ret;
    logic                sel_wfi;
    logic [8:0]          sel_exc;
    logic [WORD_W-1:0]   sel_bad;

    // Event prioritisation; the interrupt wins and reports no exception bit.
    always_comb begin : prioritise
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        exc_eff              = ex_exc;
        exc_eff[EXC_FAULT_I] = ex_exc[EXC_FAULT_I] | prot_fault_i;
        exc_eff[EXC_FAULT_L] = ex_exc[EXC_FAULT_L] | prot_fault_l;
        exc_eff[EXC_FAULT_S] = ex_exc[EXC_FAULT_S] | prot_fault_s;
        sel_trap = 1'b0;
        sel_ret  = 1'b0;
        sel_wfi  = 1'b0;
        sel_exc  = '0;
        sel_bad  = '0;
        if (priv_intr) begin
            sel_trap = 1'b1;
        end else if (exc_eff[EXC_FAULT_I]) begin
            sel_trap             = 1'b1;
            sel_exc[EXC_FAULT_I] = 1'b1;
            sel_bad              = ex_pc;
        end else if (exc_eff[EXC_MAL_I]) begin
            sel_trap           = 1'b1;
            sel_exc[EXC_MAL_I] = 1'b1;
            sel_bad            = ex_pc;
        end else if (exc_eff[EXC_ILLEGAL]) begin
            sel_trap             = 1'b1;
            sel_exc[EXC_ILLEGAL] = 1'b1;
            sel_bad              = ex_insn;
        end else if (exc_eff[EXC_BREAK]) begin
            sel_trap           = 1'b1;
            sel_exc[EXC_BREAK] = 1'b1;
        end else if (exc_eff[EXC_ENV]) begin
            sel_trap         = 1'b1;
            sel_exc[EXC_ENV] = 1'b1;
        end else if (exc_eff[EXC_MAL_L]) begin
            sel_trap           = 1'b1;
            sel_exc[EXC_MAL_L] = 1'b1;
            sel_bad            = ex_mem_addr;
        end else if (exc_eff[EXC_MAL_S]) begin
            sel_trap           = 1'b1;
            sel_exc[EXC_MAL_S] = 1'b1;
            sel_bad            = ex_mem_addr;
        end else if (exc_eff[EXC_FAULT_L]) begin
            sel_trap             = 1'b1;
            sel_exc[EXC_FAULT_L] = 1'b1;
            sel_bad              = ex_mem_addr;
        end else if (exc_eff[EXC_FAULT_S]) begin
            sel_trap             = 1'b1;
            sel_exc[EXC_FAULT_S] = 1'b1;
            sel_bad              = ex_mem_addr;
        end else if (ex_ret) begin
            sel_trap = 1'b1;
            sel_ret  = 1'b1;
        end else if (ex_wfi) begin
            sel_wfi = 1'b1;
        end
    end

    always_comb begin : next_state
        state_d          = state_q;
        exc_d            = '0;
        ret_d            = 1'b0;
        wfi_d            = 1'b0;
        epc_d            = epc_q;
        bad_d            = bad_q;
        pipe_clear_d     = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        timeout_d        = timeout_q;
        wait_cnt_d       = wait_cnt_q;
        flush_cnt_d      = flush_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (ex_valid && sel_trap) begin
                    state_d = S_REPORT;
                    exc_d   = sel_exc;
                    ret_d   = sel_ret;
                    epc_d   = ex_pc;
                    bad_d   = sel_bad;
                end else if (ex_valid && sel_wfi) begin
                    wfi_d = 1'b1;
                end
            end
            S_REPORT: begin
                state_d    = S_WAIT_PC;
                wait_cnt_d = '0;
            end
            S_WAIT_PC: begin
                // A target presented on the last waiting cycle still beats the timeout.
                if (priv_insert_pc) begin
                    state_d          = S_FLUSH;
                    redirect_pc_d    = priv_pc;
                    redirect_valid_d = 1'b1;
                    pipe_clear_d     = 1'b1;
                    flush_cnt_d      = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d      = S_FLUSH;
                        timeout_d    = 1'b1;
                        pipe_clear_d = 1'b1;
                        flush_cnt_d  = '0;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d  = flush_cnt_q + FCNT_W'(1);
                    pipe_clear_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stall_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q          <= S_IDLE;
            exc_q            <= '0;
            ret_q            <= 1'b0;
            wfi_q            <= 1'b0;
            epc_q            <= '0;
            bad_q            <= '0;
            pipe_clear_q     <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            timeout_q        <= 1'b0;
            wait_cnt_q       <= '0;
            flush_cnt_q      <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            state_q          <= state_d;
            exc_q            <= exc_d;
            ret_q            <= ret_d;
            wfi_q            <= wfi_d;
            epc_q            <= epc_d;
            bad_q            <= bad_d;
            pipe_clear_q     <= pipe_clear_d;
            stall_q          <= stall_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            timeout_q        <= timeout_d;
            wait_cnt_q       <= wait_cnt_d;
            flush_cnt_q      <= flush_cnt_d;
        end
    end

    assign exc_out        = exc_q;
    assign ret_out        = ret_q;
    assign wfi_out        = wfi_q;
    assign epc            = epc_q;
    assign badaddr        = bad_q;
    assign pipe_clear     = pipe_clear_q;
    assign stall          = stall_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: directed test-plan transactions plus random traffic, all
// checked every cycle against a transaction-level model of the trap report and handshake.
module tb_prv_trap_sequencer;

    localparam int MAX_WAIT = 15;
    localparam int FLUSH    = 2;

    typedef enum int {K_NONE, K_TRAP, K_WFI} kind_e;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] addr;
        logic [8:0]  exc;
        logic        ret;
        logic        wfi;
        logic        pi;
        logic        pl;
        logic        ps;
        logic        intr;
    } ev_t;

    typedef struct {
        int          cyc;
        logic [8:0]  exc;
        logic        ret;
        logic        wfi;
        logic [31:0] epc;
        logic [31:0] bad;
        logic        pclr;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        to;
    } exp_t;

    logic        CLK;
    logic        nRST;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_insn;
    logic [31:0] ex_mem_addr;
    logic [8:0]  ex_exc;
    logic        ex_ret;
    logic        ex_wfi;
    logic        prot_fault_i;
    logic        prot_fault_l;
    logic        prot_fault_s;
    logic        priv_intr;
    logic        priv_insert_pc;
    logic [31:0] priv_pc;
    logic [8:0]  exc_out;
    logic        ret_out;
    logic        wfi_out;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic        pipe_clear;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        timeout_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    exp_t cmp_x;

    // Architectural state the model carries between transactions.
    logic [31:0] m_epc = '0;
    logic [31:0] m_bad = '0;
    logic [31:0] m_rpc = '0;
    logic        m_to  = 1'b0;

    prv_trap_sequencer #(
        .WORD_W      (32),
        .FLUSH_CYCLES(FLUSH),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_insn       (ex_insn),
        .ex_mem_addr   (ex_mem_addr),
        .ex_exc        (ex_exc),
        .ex_ret        (ex_ret),
        .ex_wfi        (ex_wfi),
        .prot_fault_i  (prot_fault_i),
        .prot_fault_l  (prot_fault_l),
        .prot_fault_s  (prot_fault_s),
        .priv_intr     (priv_intr),
        .priv_insert_pc(priv_insert_pc),
        .priv_pc       (priv_pc),
        .exc_out       (exc_out),
        .ret_out       (ret_out),
        .wfi_out       (wfi_out),
        .epc           (epc),
        .badaddr       (badaddr),
        .pipe_clear    (pipe_clear),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .timeout_err   (timeout_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_exc"},   32'(exc_out), 32'd0);
        check({tag, "_ret"},   32'(ret_out), 32'd0);
        check({tag, "_wfi"},   32'(wfi_out), 32'd0);
        check({tag, "_epc"},   epc, 32'd0);
        check({tag, "_bad"},   badaddr, 32'd0);
        check({tag, "_pclr"},  32'(pipe_clear), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_rv"},    32'(redirect_valid), 32'd0);
        check({tag, "_rpc"},   redirect_pc, 32'd0);
        check({tag, "_to"},    32'(timeout_err), 32'd0);
    endtask

    // Compare process: every cycle that has a predicted output vector is checked.
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            cmp_x = exp_q.pop_front();
            check("exc_out",        32'(exc_out),        32'(cmp_x.exc));
            check("ret_out",        32'(ret_out),        32'(cmp_x.ret));
            check("wfi_out",        32'(wfi_out),        32'(cmp_x.wfi));
            check("epc",            epc,                 cmp_x.epc);
            check("badaddr",        badaddr,             cmp_x.bad);
            check("pipe_clear",     32'(pipe_clear),     32'(cmp_x.pclr));
            check("stall",          32'(stall),          32'(cmp_x.stall));
            check("redirect_valid", 32'(redirect_valid), 32'(cmp_x.rv));
            check("redirect_pc",    redirect_pc,         cmp_x.rpc);
            check("timeout_err",    32'(timeout_err),    32'(cmp_x.to));
        end
    end

    // Priority is a table walk; the interrupt and the return/WFI sit outside the table.
    function automatic void classify(input ev_t e, output kind_e kind, output logic [8:0] oh,
                                     output logic r, output logic [31:0] b);
        int          prio [9];
        logic [8:0]  raw;
        int          idx;
        prio = '{1, 0, 2, 3, 4, 5, 7, 6, 8};
        raw = e.exc;
        raw[1] = raw[1] | e.pi;
        raw[6] = raw[6] | e.pl;
        raw[8] = raw[8] | e.ps;
        kind = K_NONE;
        oh   = '0;
        r    = 1'b0;
        b    = '0;
        if (!e.valid) return;
        if (e.intr) begin
            kind = K_TRAP;
            return;
        end
        for (int i = 0; i < 9; i++) begin
            idx = prio[i];
            if (raw[idx]) begin
                kind    = K_TRAP;
                oh[idx] = 1'b1;
                case (idx)
                    0, 1:    b = e.pc;
                    2:       b = e.insn;
                    3, 4:    b = '0;
                    default: b = e.addr;
                endcase
                return;
            end
        end
        if (e.ret) begin
            kind = K_TRAP;
            r    = 1'b1;
        end else if (e.wfi) begin
            kind = K_WFI;
        end
    endfunction

    function automatic exp_t base_exp();
        exp_t x;
        x.cyc   = 0;
        x.exc   = '0;
        x.ret   = 1'b0;
        x.wfi   = 1'b0;
        x.epc   = m_epc;
        x.bad   = m_bad;
        x.pclr  = 1'b0;
        x.stall = 1'b0;
        x.rv    = 1'b0;
        x.rpc   = m_rpc;
        x.to    = m_to;
        return x;
    endfunction

    function automatic ev_t rand_ev();
        ev_t e;
        e.valid = ($urandom_range(0, 3) != 0);
        e.pc    = $urandom;
        e.insn  = $urandom;
        e.addr  = $urandom;
        for (int i = 0; i < 9; i++) e.exc[i] = ($urandom_range(0, 7) == 0);
        e.ret   = ($urandom_range(0, 4) == 0);
        e.wfi   = ($urandom_range(0, 4) == 0);
        e.pi    = ($urandom_range(0, 11) == 0);
        e.pl    = ($urandom_range(0, 11) == 0);
        e.ps    = ($urandom_range(0, 11) == 0);
        e.intr  = ($urandom_range(0, 9) == 0);
        return e;
    endfunction

    function automatic ev_t quiet_ev();
        ev_t e;
        e = '{default: '0};
        e.valid = 1'b1;
        return e;
    endfunction

    // Drives one cycle of inputs and queues the outputs they must produce after the edge.
    task automatic drive(input ev_t e, input logic ins, input logic [31:0] ppc, input exp_t x);
        ex_valid       = e.valid;
        ex_pc          = e.pc;
        ex_insn        = e.insn;
        ex_mem_addr    = e.addr;
        ex_exc         = e.exc;
        ex_ret         = e.ret;
        ex_wfi         = e.wfi;
        prot_fault_i   = e.pi;
        prot_fault_l   = e.pl;
        prot_fault_s   = e.ps;
        priv_intr      = e.intr;
        priv_insert_pc = ins;
        priv_pc        = ppc;
        x.cyc          = cyc + 1;
        exp_q.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    // One transaction. ins_wait: waiting cycle (0-based) on which the target arrives,
    // -1 for none. stop_after >= 0 abandons the sequence after that many follow-up cycles.
    task automatic run_txn(input ev_t e, input int ins_wait, input logic [31:0] tgt,
                           input int stop_after);
        kind_e       kind;
        logic [8:0]  oh;
        logic        r;
        logic [31:0] b;
        exp_t        x;
        int          w;
        int          last;
        classify(e, kind, oh, r, b);
        if (kind == K_TRAP) begin
            m_epc = e.pc;
            m_bad = b;
        end
        x = base_exp();
        if (kind == K_TRAP) begin
            x.exc   = oh;
            x.ret   = r;
            x.stall = 1'b1;
        end else if (kind == K_WFI) begin
            x.wfi = 1'b1;
        end
        drive(e, ($urandom_range(0, 1) == 1), $urandom, x);
        if (kind != K_TRAP) return;
        w    = (ins_wait >= 0) ? ins_wait + 1 : MAX_WAIT;
        last = 1 + w + FLUSH;
        for (int s = 1; s <= last; s++) begin
            logic        ins;
            logic [31:0] ppc;
            int          c;
            if (stop_after >= 0 && s > stop_after) return;
            ins = ($urandom_range(0, 1) == 1);
            ppc = $urandom;
            if (s >= 2 && s <= 1 + w) begin
                ins = (ins_wait >= 0 && s == 1 + w);
                if (ins) ppc = tgt;
            end
            c = s + 1;
            if (c == 2 + w) begin
                if (ins_wait >= 0) m_rpc = tgt;
                else               m_to  = 1'b1;
            end
            x       = base_exp();
            x.stall = (c <= last);
            x.pclr  = (c >= 2 + w && c <= last);
            x.rv    = (c == 2 + w && ins_wait >= 0);
            drive(rand_ev(), ins, ppc, x);
        end
    endtask

    task automatic set_inputs_idle();
        ex_valid = 1'b0; ex_pc = '0; ex_insn = '0; ex_mem_addr = '0; ex_exc = '0;
        ex_ret = 1'b0; ex_wfi = 1'b0; prot_fault_i = 1'b0; prot_fault_l = 1'b0;
        prot_fault_s = 1'b0; priv_intr = 1'b0; priv_insert_pc = 1'b0; priv_pc = '0;
    endtask

    initial begin
        ev_t         e;
        kind_e       k;
        logic [8:0]  oh;
        logic        r;
        logic [31:0] b;

        nRST = 1'b0;
        set_inputs_idle();
        repeat (3) @(posedge CLK);
        #1 check_zero("reset");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Illegal instruction, target on the first waiting cycle.
        e = quiet_ev(); e.pc = 32'h200; e.insn = 32'hFFFF_FFFF; e.exc[2] = 1'b1;
        classify(e, k, oh, r, b);
        check("pin_ill_exc", 32'(oh), 32'h004);
        check("pin_ill_bad", b, 32'hFFFF_FFFF);
        run_txn(e, 0, 32'h80, -1);
        check("ill_epc_hold", epc, 32'h200);
        check("ill_bad_hold", badaddr, 32'hFFFF_FFFF);
        check("ill_rpc", redirect_pc, 32'h80);
        check("ill_stall_low", 32'(stall), 32'd0);

        // Breakpoint outranks misaligned load and store fault.
        e = quiet_ev(); e.pc = 32'h240; e.addr = 32'h1003;
        e.exc[5] = 1'b1; e.exc[8] = 1'b1; e.exc[3] = 1'b1;
        classify(e, k, oh, r, b);
        check("pin_multi_exc", 32'(oh), 32'h008);
        check("pin_multi_bad", b, 32'd0);
        run_txn(e, 2, 32'h1234, -1);

        // Interrupt beats env call.
        e = quiet_ev(); e.pc = 32'h40; e.exc[4] = 1'b1; e.intr = 1'b1;
        classify(e, k, oh, r, b);
        check("pin_intr_exc", 32'(oh), 32'd0);
        check("pin_intr_kind", 32'(k == K_TRAP), 32'd1);
        run_txn(e, 1, 32'h500, -1);
        check("intr_epc", epc, 32'h40);
        check("intr_bad", badaddr, 32'd0);

        // Return.
        e = quiet_ev(); e.pc = 32'h88; e.ret = 1'b1;
        classify(e, k, oh, r, b);
        check("pin_ret", 32'(r), 32'd1);
        run_txn(e, 0, 32'h300, -1);
        check("ret_rpc", redirect_pc, 32'h300);

        // WFI alone: pulse only, no stall.
        e = quiet_ev(); e.pc = 32'h90; e.wfi = 1'b1;
        classify(e, k, oh, r, b);
        check("pin_wfi_kind", 32'(k == K_WFI), 32'd1);
        run_txn(e, 0, 32'h0, -1);
        run_txn(quiet_ev(), 0, 32'h0, -1);

        // Timeout: no target ever presented.
        e = quiet_ev(); e.pc = 32'h600; e.insn = 32'h1; e.exc[2] = 1'b1;
        run_txn(e, -1, 32'h0, -1);
        check("to_flag", 32'(timeout_err), 32'd1);
        check("to_rpc_kept", redirect_pc, 32'h300);
        run_txn(quiet_ev(), 0, 32'h0, -1);

        // Asynchronous reset while waiting for the target.
        e = quiet_ev(); e.pc = 32'h700; e.exc[0] = 1'b1;
        run_txn(e, -1, 32'h0, 5);
        @(negedge CLK);
        #2;
        exp_q.delete();
        check("pre_rst_stall", 32'(stall), 32'd1);
        nRST = 1'b0;
        #1 check_zero("async_rst");
        m_epc = '0; m_bad = '0; m_rpc = '0; m_to = 1'b0;
        set_inputs_idle();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            int iw;
            if ($urandom_range(0, 9) == 0)      iw = -1;
            else if ($urandom_range(0, 3) == 0) iw = $urandom_range(0, MAX_WAIT - 1);
            else                                iw = $urandom_range(0, 2);
            run_txn(rand_ev(), iw, $urandom, -1);
        end

        @(negedge CLK);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prv_trap_sequencer.md
Name: prv_trap_sequencer

Overview:
- Sits between the execute/memory stage and the privilege block, on the hazard side of the privilege–pipeline interface.
- Collects raw exception, return, WFI and interrupt events and prioritises them into a single registered trap report: one-hot cause, epc and badaddr.
- Then sequences the redirect handshake with the privilege block: waits for insert_pc, drives pipe_clear, stalls the pipeline and issues the redirect.

Parameters:
- WORD_W, 32, width of pc/address/data words.
- FLUSH_CYCLES, 2, cycles pipe_clear is held after redirect (≥1).
- MAX_WAIT, 15, cycles to wait for priv_insert_pc before timeout (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ex_valid  in  1  instruction in EX/MEM is valid.
- ex_pc  in  WORD_W  pc of that instruction.
- ex_insn  in  WORD_W  instruction bits.
- ex_mem_addr  in  WORD_W  load/store effective address.
- ex_exc  in  9  raw flags [0]mal_insn [1]fault_insn [2]illegal_insn [3]breakpoint [4]env [5]mal_l [6]fault_l [7]mal_s [8]fault_s.
- ex_ret  in  1  xRET in EX/MEM.
- ex_wfi  in  1  WFI in EX/MEM.
- prot_fault_i/prot_fault_l/prot_fault_s  in  1 each  PMA/PMP faults; ORed into fault_insn/fault_l/fault_s.
- priv_intr  in  1  pending enabled interrupt.
- priv_insert_pc  in  1  privilege block presents target pc.
- priv_pc  in  WORD_W  trap/return target.
- exc_out  out  9  registered one-hot exception, same bit order as ex_exc.
- ret_out  out  1  registered return request.
- wfi_out  out  1  one-cycle WFI pulse.
- epc  out  WORD_W  pc of trapping instruction.
- badaddr  out  WORD_W  fault value.
- pipe_clear  out  1  flush request.
- stall  out  1  freeze fetch/execute.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  WORD_W  redirect target.
- timeout_err  out  1  sticky handshake timeout flag.

Behaviour:
- Reset: all outputs 0; state IDLE; wait counter 0. The async assert takes effect immediately, mid-sequence included, and discards any in-flight report.
- FSM states: IDLE, REPORT, WAIT_PC, FLUSH.
- Event acceptance: events are sampled only in IDLE with ex_valid=1; all ex_* inputs are ignored in other states.
- Priority (highest first): priv_intr, fault_insn, mal_insn, illegal_insn, breakpoint, env, mal_l, mal_s, fault_l, fault_s, ret, wfi.
  - Interrupt beats a simultaneous exception: exc_out=0, the instruction is not committed, and epc=ex_pc.
- IDLE, trap/intr/ret selected → REPORT at N+1:
  - exc_out holds the one-hot winner, or ret_out=1.
  - epc=ex_pc.
  - badaddr: ex_pc for insn faults/mal; ex_insn for illegal; ex_mem_addr for load/store; 0 for breakpoint, env, intr and ret.
  - stall=1 from N+1 until return to IDLE.
- IDLE, wfi only: wfi_out pulses at N+1; state stays IDLE; no stall.
- REPORT: outputs held for exactly one cycle, then cleared → WAIT_PC; counter=0.
- WAIT_PC:
  - priv_insert_pc=1 → capture priv_pc into redirect_pc, pulse redirect_valid for 1 cycle, enter FLUSH.
  - Otherwise increment the counter; at counter==MAX_WAIT set timeout_err (sticky until reset) and go to FLUSH with no redirect.
- FLUSH: pipe_clear=1 for exactly FLUSH_CYCLES cycles, then IDLE. stall drops the same cycle IDLE is entered.
- priv_insert_pc outside WAIT_PC: ignored.
- epc/badaddr: hold their last value until the next accepted event.
- Minimum trap turnaround (insert_pc asserted in the first WAIT_PC cycle): 3+FLUSH_CYCLES cycles.

Test Plan:
- Illegal insn at ex_pc=0x200, ex_insn=0xFFFFFFFF; insert_pc next cycle with priv_pc=0x80 → exc_out=0x004, epc=0x200, badaddr=0xFFFFFFFF for 1 cycle; redirect_pc=0x80; pipe_clear high 2 cycles; stall low after.
- mal_l+fault_s+breakpoint together, ex_mem_addr=0x1003 → exc_out=0x008 (breakpoint), badaddr=0.
- priv_intr with env at ex_pc=0x40 → exc_out=0, epc=0x40, redirect after insert_pc.
- ex_ret, priv_pc=0x300 → ret_out=1 one cycle, redirect_valid pulse with 0x300.
- ex_wfi alone → wfi_out single pulse, stall stays 0.
- No insert_pc → timeout_err=1 after MAX_WAIT=15 cycles, then pipe_clear 2 cycles, redirect_valid never asserted; nRST low during WAIT_PC → all outputs 0 immediately.
